// File: rtl/pq_pkg.sv
// pq_pkg: shared types and constants for the priority-queue host and device blocks.
`default_nettype none
package pq_pkg;
  localparam int KEY_W       = 8;
  localparam int VAL_W       = 8;
  localparam int PQ_CAPACITY = 7;
  localparam int PQ_CNT_W    = $clog2(PQ_CAPACITY + 1);

  typedef logic [KEY_W-1:0] key_t;
  typedef logic [VAL_W-1:0] val_t;

  typedef struct packed {
    key_t key;
    val_t val;
  } kv_t;

  localparam key_t KEY0     = '0;
  localparam val_t VAL0     = '0;
  localparam kv_t  EMPTY_KV = '{key: KEY0, val: VAL0};

  typedef enum logic [0:0] {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } pqs_state_t;
endpackage
`default_nettype wire

// File: rtl/pq_if.sv
// pq_if: command/status bundle between a priority-queue host and a queue device.
`default_nettype none
interface pq_if
  import pq_pkg::*;
;
  logic rst;
  logic enq;
  logic deq;
  kv_t  kvi;
  kv_t  kvo;
  logic full;
  logic empty;
  logic busy;

  modport host (output enq, deq, kvi, input kvo, full, empty, busy);
  modport dev  (input rst, enq, deq, kvi, output kvo, full, empty, busy);
endinterface
`default_nettype wire

// File: rtl/heap_pq.sv
// heap_pq: single-cycle priority queue kept as a sorted array; head (slot 0) is the minimum key.
`default_nettype none
module heap_pq
  import pq_pkg::*;
(
  input logic clk,
  pq_if.dev   pq
);
  kv_t                    mem   [PQ_CAPACITY];
  kv_t                    below [PQ_CAPACITY];
  kv_t                    above [PQ_CAPACITY];
  logic [PQ_CAPACITY-1:0] keep;
  logic [PQ_CAPACITY-1:0] keep_prev;
  logic [PQ_CNT_W-1:0]    count;
  logic                   full;
  logic                   empty;

  assign full     = (count == PQ_CNT_W'(PQ_CAPACITY));
  assign empty    = (count == '0);
  assign pq.full  = full;
  assign pq.empty = empty;
  assign pq.busy  = 1'b0;
  assign pq.kvo   = mem[0];

  // keep[i]: slot i stays put on insert; the first non-kept slot takes the new item,
  // later slots take their lower neighbour. Equal keys insert after existing ones.
  always_comb begin
    for (int i = 0; i < PQ_CAPACITY; i++) begin
      keep[i]  = (PQ_CNT_W'(i) < count) && (mem[i].key <= pq.kvi.key);
      below[i] = pq.kvi;
      above[i] = EMPTY_KV;
    end
    for (int i = 1; i < PQ_CAPACITY; i++) begin
      below[i] = mem[i-1];
    end
    for (int i = 0; i < PQ_CAPACITY - 1; i++) begin
      above[i] = mem[i+1];
    end
    keep_prev = {keep[PQ_CAPACITY-2:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (pq.rst) begin
      count <= '0;
      for (int i = 0; i < PQ_CAPACITY; i++) mem[i] <= EMPTY_KV;
    end else if (pq.enq && !full) begin
      count <= count + PQ_CNT_W'(1);
      for (int i = 0; i < PQ_CAPACITY; i++) begin
        if (!keep[i]) mem[i] <= keep_prev[i] ? pq.kvi : below[i];
      end
    end else if (pq.deq && !empty) begin
      count <= count - PQ_CNT_W'(1);
      for (int i = 0; i < PQ_CAPACITY; i++) mem[i] <= above[i];
    end
  end
endmodule
`default_nettype wire

// File: rtl/pq_out_reg.sv
// pq_out_reg: single-entry valid/ready output register with a load enable.
`default_nettype none
module pq_out_reg
  import pq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  kv_t  d_kv,
  input  logic d_last,
  input  logic ready,
  output logic valid,
  output kv_t  kv,
  output logic last
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      kv    <= EMPTY_KV;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      kv    <= d_kv;
      last  <= d_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule
`default_nettype wire

// File: rtl/pq_sorter.sv
// pq_sorter: loads a frame into an attached priority queue, then drains it as an ascending-key stream.
`default_nettype none
module pq_sorter
  import pq_pkg::*;
#(
  parameter int CNT_W = $clog2(PQ_CAPACITY + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  pq_if.host         pi,
  input  logic       in_valid,
  output logic       in_ready,
  input  kv_t        in_kv,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output kv_t        out_kv,
  output logic       out_last,
  output logic       ovf
);
  pqs_state_t       state;
  pqs_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             at_cap;

  // The accepted item is the one that fills the queue.
  assign at_cap = (cnt == CNT_W'(PQ_CAPACITY - 1));

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    load       = 1'b0;
    pi.enq     = 1'b0;
    pi.deq     = 1'b0;
    pi.kvi     = in_kv;
    case (state)
      LOAD: begin
        in_ready = rst_n && !pi.full && !pi.busy;
        if (in_valid && in_ready) begin
          pi.enq = 1'b1;
          if (in_last || at_cap) state_next = DRAIN;
        end
      end
      DRAIN: begin
        load   = (!out_valid || out_ready) && !pi.empty && !pi.busy && (cnt != '0);
        pi.deq = load;
        if (out_valid && out_ready && out_last) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      if (pi.enq)      cnt <= cnt + CNT_W'(1);
      else if (pi.deq) cnt <= cnt - CNT_W'(1);
      if (pi.enq && at_cap && !in_last) ovf <= 1'b1;
    end
  end

  pq_out_reg u_out (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .d_kv   (pi.kvo),
    .d_last (cnt == CNT_W'(1)),
    .ready  (out_ready),
    .valid  (out_valid),
    .kv     (out_kv),
    .last   (out_last)
  );

`ifndef SYNTHESIS
  // Once the count runs out in DRAIN, only the final item may still be waiting.
  a_cnt_live: assert property (@(posedge clk) disable iff (!rst_n)
    (state == DRAIN && cnt == '0) |-> (out_valid && out_last));
`endif
endmodule
`default_nettype wire

// File: tb/tb_pq_sorter.sv
// tb_pq_sorter: randomized and directed checks of pq_sorter + heap_pq against a sort model.
`default_nettype none
module tb_pq_sorter;
  import pq_pkg::*;

  typedef struct {
    kv_t kv;
    bit  last;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  kv_t  in_kv = EMPTY_KV;
  logic in_last = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  kv_t  out_kv;
  logic out_last;
  logic ovf;

  int total = 0;
  int bad = 0;

  item_t in_q[$];
  kv_t   exp_kv[$];
  bit    exp_last[$];
  bit    exp_split;
  kv_t   got_kv[$];
  bit    got_last[$];
  int    stab_bad;
  bit    drv_to;
  bit    col_to;

  int proto_bad = 0;
  int enq_cnt = 0;
  int deq_cnt = 0;

  pq_if pi ();
  assign pi.rst = ~rst_n;

  heap_pq u_pq (.clk(clk), .pq(pi));

  pq_sorter dut (
    .clk(clk), .rst_n(rst_n), .pi(pi),
    .in_valid(in_valid), .in_ready(in_ready), .in_kv(in_kv), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_kv(out_kv), .out_last(out_last),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pi.enq && pi.deq) proto_bad++;
      if ((pi.enq || pi.deq) && pi.busy) proto_bad++;
      if (pi.enq && pi.full) proto_bad++;
      if (pi.deq && pi.empty) proto_bad++;
      if (pi.enq) enq_cnt++;
      if (pi.deq) deq_cnt++;
    end
  end

  task automatic push_item(input int key, input int val, input bit last);
    item_t it;
    it.kv   = '{key: key_t'(key), val: val_t'(val)};
    it.last = last;
    in_q.push_back(it);
  endtask

  // Reference: split at each last flag or when a segment reaches capacity, emit each segment min-first.
  task automatic build_expected();
    kv_t seg[$];
    int  m;
    exp_kv.delete();
    exp_last.delete();
    exp_split = 0;
    foreach (in_q[i]) begin
      seg.push_back(in_q[i].kv);
      if (in_q[i].last || seg.size() == PQ_CAPACITY) begin
        if (!in_q[i].last) exp_split = 1;
        while (seg.size() > 0) begin
          m = 0;
          foreach (seg[j]) if (seg[j].key < seg[m].key) m = j;
          exp_kv.push_back(seg[m]);
          exp_last.push_back(seg.size() == 1);
          seg.delete(m);
        end
      end
    end
  endtask

  task automatic drive(input int budget);
    int idx = 0;
    drv_to = 0;
    for (int t = 0; idx < in_q.size(); t++) begin
      if (t >= budget) begin
        drv_to = 1;
        break;
      end
      in_valid = 1'b1;
      in_kv    = in_q[idx].kv;
      in_last  = in_q[idx].last;
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect(input int nseg, input int mode, input int max_out, input int budget);
    int  segs = 0;
    int  n = 0;
    bit  stall = 0;
    kv_t held = EMPTY_KV;
    col_to = 0;
    got_kv.delete();
    got_last.delete();
    stab_bad = 0;
    for (int t = 0; segs < nseg && n < max_out; t++) begin
      if (t >= budget) begin
        col_to = 1;
        break;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (t % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (stall && out_kv !== held) stab_bad++;
      if (out_valid && out_ready) begin
        got_kv.push_back(out_kv);
        got_last.push_back(out_last);
        n++;
        if (out_last) segs++;
      end
      stall = out_valid && !out_ready;
      held  = out_kv;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic run_frame(input int mode, input int max_out);
    int nseg = 0;
    build_expected();
    foreach (exp_last[i]) if (exp_last[i]) nseg++;
    fork
      drive(400);
      collect(nseg, mode, max_out, 400);
    join
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset out_last: got %b want 0", out_last); end
    total++; if (out_kv !== EMPTY_KV) begin bad++; $display("FAIL reset out_kv: got %h want %h", out_kv, EMPTY_KV); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset ovf: got %b want 0", ovf); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
    total++; if (pi.enq !== 1'b0 || pi.deq !== 1'b0) begin bad++; $display("FAIL reset enq/deq: got %b%b want 00", pi.enq, pi.deq); end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset release in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    in_q.delete();
    push_item(5, 50, 0); push_item(3, 30, 0); push_item(9, 90, 0); push_item(1, 10, 1);
    run_frame(0, 1000);
    total++; if (drv_to || col_to) begin bad++; $display("FAIL basic timeout: got drv=%b col=%b want 00", drv_to, col_to); end
    total++; if (got_kv.size() != exp_kv.size()) begin bad++; $display("FAIL basic count: got %0d want %0d", got_kv.size(), exp_kv.size()); end
    foreach (exp_kv[i]) if (i < got_kv.size()) begin
      total++;
      if (got_kv[i] !== exp_kv[i] || got_last[i] !== exp_last[i]) begin
        bad++; $display("FAIL basic item%0d: got %h/%b want %h/%b", i, got_kv[i], got_last[i], exp_kv[i], exp_last[i]);
      end
    end
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic back_to_load: got in_ready=%b want 1", in_ready); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL basic ovf: got %b want 0", ovf); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int e0 = enq_cnt;
    int d0 = deq_cnt;
    in_q.delete();
    push_item(8, 81, 0); push_item(2, 21, 0); push_item(6, 61, 1);
    run_frame(1, 1000);
    total++; if (drv_to || col_to) begin bad++; $display("FAIL bp timeout: got drv=%b col=%b want 00", drv_to, col_to); end
    total++; if (got_kv.size() != exp_kv.size()) begin bad++; $display("FAIL bp count: got %0d want %0d", got_kv.size(), exp_kv.size()); end
    foreach (exp_kv[i]) if (i < got_kv.size()) begin
      total++;
      if (got_kv[i] !== exp_kv[i] || got_last[i] !== exp_last[i]) begin
        bad++; $display("FAIL bp item%0d: got %h/%b want %h/%b", i, got_kv[i], got_last[i], exp_kv[i], exp_last[i]);
      end
    end
    total++; if (stab_bad != 0) begin bad++; $display("FAIL bp stable: got %0d changes want 0", stab_bad); end
    total++; if (deq_cnt - d0 != 3) begin bad++; $display("FAIL bp deq pulses: got %0d want 3", deq_cnt - d0); end
    total++; if (enq_cnt - e0 != 3) begin bad++; $display("FAIL bp enq pulses: got %0d want 3", enq_cnt - e0); end
  endtask

  task automatic test_single();
    in_valid = 1'b1;
    in_kv    = '{key: 8'd4, val: 8'h44};
    in_last  = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single accept: got in_ready=%b want 1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    total++; if (pi.deq !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL single n+1: got deq=%b in_ready=%b want 1 0", pi.deq, in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single early valid: got %b want 0", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_kv !== kv_t'({8'd4, 8'h44}) || out_last !== 1'b1) begin
      bad++; $display("FAIL single n+2: got v=%b kv=%h last=%b want 1 0444 1", out_valid, out_kv, out_last);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL single done: got in_ready=%b v=%b want 1 0", in_ready, out_valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_overflow();
    in_q.delete();
    for (int k = 9; k >= 1; k--) push_item(k, 16 * k, k == 1);
    run_frame(0, 1000);
    total++; if (drv_to || col_to) begin bad++; $display("FAIL ovf timeout: got drv=%b col=%b want 00", drv_to, col_to); end
    total++; if (got_kv.size() != exp_kv.size()) begin bad++; $display("FAIL ovf count: got %0d want %0d", got_kv.size(), exp_kv.size()); end
    foreach (exp_kv[i]) if (i < got_kv.size()) begin
      total++;
      if (got_kv[i] !== exp_kv[i] || got_last[i] !== exp_last[i]) begin
        bad++; $display("FAIL ovf item%0d: got %h/%b want %h/%b", i, got_kv[i], got_last[i], exp_kv[i], exp_last[i]);
      end
    end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf flag: got %b want 1", ovf); end
  endtask

  task automatic test_reset_mid_drain();
    int d0;
    in_q.delete();
    push_item(10, 1, 0); push_item(40, 4, 0); push_item(20, 2, 0); push_item(50, 5, 0); push_item(30, 3, 1);
    run_frame(0, 2);
    total++; if (got_kv.size() != 2) begin bad++; $display("FAIL rst partial count: got %0d want 2", got_kv.size()); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_kv !== EMPTY_KV) begin
      bad++; $display("FAIL rst outputs: got v=%b last=%b kv=%h want 0 0 %h", out_valid, out_last, out_kv, EMPTY_KV);
    end
    total++; if (in_ready !== 1'b0 || ovf !== 1'b0) begin bad++; $display("FAIL rst flags: got in_ready=%b ovf=%b want 0 0", in_ready, ovf); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    d0 = deq_cnt;
    in_q.delete();
    push_item(7, 77, 0); push_item(0, 99, 1);
    run_frame(0, 1000);
    total++; if (got_kv.size() != exp_kv.size()) begin bad++; $display("FAIL rst new count: got %0d want %0d", got_kv.size(), exp_kv.size()); end
    foreach (exp_kv[i]) if (i < got_kv.size()) begin
      total++;
      if (got_kv[i] !== exp_kv[i] || got_last[i] !== exp_last[i]) begin
        bad++; $display("FAIL rst new item%0d: got %h/%b want %h/%b", i, got_kv[i], got_last[i], exp_kv[i], exp_last[i]);
      end
    end
    total++; if (deq_cnt - d0 != 2) begin bad++; $display("FAIL rst stale deq: got %0d want 2", deq_cnt - d0); end
  endtask

  task automatic test_random();
    bit [255:0] used;
    int         n;
    int         k;
    bit         any_split = 0;
    for (int f = 0; f < 6; f++) begin
      used = '0;
      n    = $urandom_range(1, 15);
      in_q.delete();
      for (int i = 0; i < n; i++) begin
        do k = $urandom_range(0, 255); while (used[k]);
        used[k] = 1'b1;
        push_item(k, $urandom_range(0, 255), i == n - 1);
      end
      run_frame(2, 1000);
      if (exp_split) any_split = 1;
      total++; if (drv_to || col_to) begin bad++; $display("FAIL rand%0d timeout: got drv=%b col=%b want 00", f, drv_to, col_to); end
      total++; if (got_kv.size() != exp_kv.size()) begin bad++; $display("FAIL rand%0d count: got %0d want %0d", f, got_kv.size(), exp_kv.size()); end
      foreach (exp_kv[i]) if (i < got_kv.size()) begin
        total++;
        if (got_kv[i] !== exp_kv[i] || got_last[i] !== exp_last[i]) begin
          bad++; $display("FAIL rand%0d item%0d: got %h/%b want %h/%b", f, i, got_kv[i], got_last[i], exp_kv[i], exp_last[i]);
        end
      end
      total++; if (stab_bad != 0) begin bad++; $display("FAIL rand%0d stable: got %0d changes want 0", f, stab_bad); end
    end
    total++; if (ovf !== any_split) begin bad++; $display("FAIL rand ovf: got %b want %b", ovf, any_split); end
  endtask

  task automatic test_protocol();
    total++; if (proto_bad != 0) begin bad++; $display("FAIL protocol: got %0d violations want 0", proto_bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_single();
    test_overflow();
    test_reset_mid_drain();
    test_random();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
